// File: rtl/entrada_captura.sv
`default_nettype none
// ============================================================================
//  Module      : entrada_captura
//  Description : Debounced push-button capture of a 4-bit switch value for the
//                processor input port, with ready/overrun flags and a stall
//                request while an input read waits for data.
//  Revision    : 1.0 - initial release
// ============================================================================
module entrada_captura #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic PRESS_LEVEL     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        botaoIN,
    input  logic [3:0]  entradaDeDados,
    input  logic [1:0]  entradaSaidaControl,
    output logic [3:0]  dadoCapturado,
    output logic [31:0] dadoEstendido,
    output logic        dadoPronto,
    output logic        sobrescrita,
    output logic        paraProcessador
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1, so it can never wrap.
    localparam int                 c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [1:0]         c_CTL_READ = 2'b10;

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        FILTRA_PRESS = 2'd1,
        PRESSIONADO  = 2'd2,
        FILTRA_SOLTA = 2'd3
    } estado_t;

    logic               r_botao_meta;
    logic               r_botaoS;
    logic [3:0]         r_chaves_meta;
    logic [3:0]         r_chavesS;

    estado_t            r_estado;
    logic [c_CNT_W-1:0] r_contador;
    logic [3:0]         r_dadoCapturado;
    logic               r_dadoPronto;
    logic               r_sobrescrita;

    logic               w_pressed;
    logic               w_read;
    logic               w_consume;
    logic               w_cnt_done;
    logic               w_capture;

    assign w_pressed  = (r_botaoS == PRESS_LEVEL);
    assign w_read     = (entradaSaidaControl == c_CTL_READ);
    assign w_consume  = w_read && r_dadoPronto;
    assign w_cnt_done = (r_contador == c_CNT_LAST);
    assign w_capture  = (r_estado == FILTRA_PRESS) && w_pressed && w_cnt_done;

    // Two-flop synchronizers; the button resets to its released level so a
    // held key is seen as a fresh press after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_botao_meta  <= ~PRESS_LEVEL;
            r_botaoS      <= ~PRESS_LEVEL;
            r_chaves_meta <= 4'h0;
            r_chavesS     <= 4'h0;
        end else begin
            r_botao_meta  <= botaoIN;
            r_botaoS      <= r_botao_meta;
            r_chaves_meta <= entradaDeDados;
            r_chavesS     <= r_chaves_meta;
        end
    end

    // Debounce FSM plus capture/consume bookkeeping; capture beats consume.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado        <= OCIOSO;
            r_contador      <= '0;
            r_dadoCapturado <= 4'h0;
            r_dadoPronto    <= 1'b0;
            r_sobrescrita   <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_pressed) begin
                        r_estado   <= FILTRA_PRESS;
                        r_contador <= '0;
                    end
                end
                FILTRA_PRESS: begin
                    if (!w_pressed) begin
                        r_estado   <= OCIOSO;
                        r_contador <= '0;
                    end else if (w_cnt_done) begin
                        r_estado   <= PRESSIONADO;
                    end else begin
                        r_contador <= r_contador + c_CNT_ONE;
                    end
                end
                PRESSIONADO: begin
                    if (!w_pressed) begin
                        r_estado   <= FILTRA_SOLTA;
                        r_contador <= '0;
                    end
                end
                FILTRA_SOLTA: begin
                    if (w_pressed) begin
                        r_estado   <= PRESSIONADO;
                        r_contador <= '0;
                    end else if (w_cnt_done) begin
                        r_estado   <= OCIOSO;
                    end else begin
                        r_contador <= r_contador + c_CNT_ONE;
                    end
                end
                default: begin
                    r_estado   <= OCIOSO;
                    r_contador <= '0;
                end
            endcase

            if (w_capture) begin
                r_dadoCapturado <= r_chavesS;
                r_dadoPronto    <= 1'b1;
                // Overrun only when unread data is overwritten without a read.
                r_sobrescrita   <= r_dadoPronto && !w_consume;
            end else if (w_consume) begin
                r_dadoPronto    <= 1'b0;
                r_sobrescrita   <= 1'b0;
            end
        end
    end

    assign dadoCapturado   = r_dadoCapturado;
    assign dadoEstendido   = {28'h0, r_dadoCapturado};
    assign dadoPronto      = r_dadoPronto;
    assign sobrescrita     = r_sobrescrita;
    assign paraProcessador = w_read && !r_dadoPronto;

endmodule
`default_nettype wire

// File: tb/tb_entrada_captura.sv
`default_nettype none
// ============================================================================
//  Module      : tb_entrada_captura
//  Description : Directed self-checking bench for entrada_captura with
//                DEBOUNCE_CYCLES = 4, PRESS_LEVEL = 0; captured values are
//                checked against a scoreboard queue filled at stimulus time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_entrada_captura;

    logic        clk = 1'b0;
    logic        reset;
    logic        botaoIN;
    logic [3:0]  entradaDeDados;
    logic [1:0]  entradaSaidaControl;
    logic [3:0]  dadoCapturado;
    logic [31:0] dadoEstendido;
    logic        dadoPronto;
    logic        sobrescrita;
    logic        paraProcessador;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_q[$];

    entrada_captura #(
        .DEBOUNCE_CYCLES (4),
        .PRESS_LEVEL     (1'b0)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .botaoIN             (botaoIN),
        .entradaDeDados      (entradaDeDados),
        .entradaSaidaControl (entradaSaidaControl),
        .dadoCapturado       (dadoCapturado),
        .dadoEstendido       (dadoEstendido),
        .dadoPronto          (dadoPronto),
        .sobrescrita         (sobrescrita),
        .paraProcessador     (paraProcessador)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected capture and compare with the DUT output
    task automatic sb_check(input string tag);
        logic [3:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, dadoCapturado);
        end else begin
            e = exp_q.pop_front();
            assert (dadoCapturado === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, dadoCapturado, e);
            end
        end
    endtask

    // Press with switch value v starting from edge 0 (caller sits 1 ns after
    // an edge, FSM idle). Returns 1 ns after edge 7, the capture edge.
    // ctl_cap is applied only for the capture edge itself.
    task automatic press_capture(input string tag, input logic [3:0] v,
                                 input logic [1:0] ctl_cap, input logic chk_latency);
        logic [1:0] ctl_saved;
        exp_q.push_back(v);
        entradaDeDados = v;
        botaoIN        = 1'b0;
        tick(6);
        if (chk_latency) chk({tag, "_not_yet"}, {31'h0, dadoPronto}, 32'h0);
        ctl_saved           = entradaSaidaControl;
        entradaSaidaControl = ctl_cap;
        tick(1);
        entradaSaidaControl = ctl_saved;
        chk({tag, "_pronto"}, {31'h0, dadoPronto}, 32'h1);
        sb_check({tag, "_dado"});
    endtask

    task automatic release_btn(input int n);
        botaoIN = 1'b1;
        tick(n);
    endtask

    initial begin
        reset               = 1'b0;
        botaoIN             = 1'b1;
        entradaDeDados      = 4'h0;
        entradaSaidaControl = 2'b00;
        tick(3);

        // Reset state
        chk("rst_pronto",  {31'h0, dadoPronto},      32'h0);
        chk("rst_dado",    {28'h0, dadoCapturado},   32'h0);
        chk("rst_ext",     dadoEstendido,            32'h0);
        chk("rst_sobre",   {31'h0, sobrescrita},     32'h0);
        chk("rst_stall",   {31'h0, paraProcessador}, 32'h0);
        reset = 1'b1;
        tick(2);

        // Clean press of 4'hA with exact latency
        press_capture("clean", 4'hA, 2'b00, 1'b1);
        chk("clean_ext",   dadoEstendido,        32'h0000000A);
        chk("clean_sobre", {31'h0, sobrescrita}, 32'h0);

        // Long hold: switches move and non-read controls toggle, no recapture
        entradaDeDados = 4'hF;
        for (int i = 0; i < 60; i++) begin
            entradaSaidaControl = (i % 3 == 0) ? 2'b01 : ((i % 3 == 1) ? 2'b11 : 2'b00);
            tick(1);
        end
        entradaSaidaControl = 2'b00;
        chk("hold_dado",   {28'h0, dadoCapturado}, 32'hA);
        chk("hold_pronto", {31'h0, dadoPronto},    32'h1);
        chk("hold_sobre",  {31'h0, sobrescrita},   32'h0);
        release_btn(12);

        // Consume: read with data waiting does not stall, clears ready
        entradaSaidaControl = 2'b10;
        #1;
        chk("cons_nostall", {31'h0, paraProcessador}, 32'h0);
        tick(1);
        entradaSaidaControl = 2'b00;
        chk("cons_pronto", {31'h0, dadoPronto},    32'h0);
        chk("cons_dado",   {28'h0, dadoCapturado}, 32'hA);

        // Glitch: three low cycles are rejected
        entradaDeDados = 4'h9;
        botaoIN        = 1'b0;
        tick(3);
        release_btn(15);
        chk("glitch_pronto", {31'h0, dadoPronto},    32'h0);
        chk("glitch_dado",   {28'h0, dadoCapturado}, 32'hA);

        // Stall then capture 4'h5 with the read held
        entradaSaidaControl = 2'b10;
        #1;
        chk("stall_on", {31'h0, paraProcessador}, 32'h1);
        press_capture("stall", 4'h5, 2'b10, 1'b1);
        chk("stall_off", {31'h0, paraProcessador}, 32'h0);
        tick(1);
        entradaSaidaControl = 2'b00;
        chk("stall_cons_pronto", {31'h0, dadoPronto},    32'h0);
        chk("stall_cons_dado",   {28'h0, dadoCapturado}, 32'h5);
        release_btn(12);

        // Overrun: 4'h3 then 4'hC without consume
        press_capture("ovr1", 4'h3, 2'b00, 1'b1);
        chk("ovr1_sobre", {31'h0, sobrescrita}, 32'h0);
        release_btn(12);
        press_capture("ovr2", 4'hC, 2'b00, 1'b0);
        chk("ovr2_sobre", {31'h0, sobrescrita}, 32'h1);
        chk("ovr2_ext",   dadoEstendido,        32'h0000000C);
        release_btn(12);
        chk("ovr_sticky", {31'h0, sobrescrita}, 32'h1);
        entradaSaidaControl = 2'b10;
        tick(1);
        entradaSaidaControl = 2'b00;
        chk("ovr_cons_sobre",  {31'h0, sobrescrita}, 32'h0);
        chk("ovr_cons_pronto", {31'h0, dadoPronto},  32'h0);

        // Simultaneous capture and consume, with overrun set beforehand
        press_capture("sim_a", 4'h1, 2'b00, 1'b1);
        release_btn(12);
        press_capture("sim_b", 4'h2, 2'b00, 1'b0);
        chk("sim_b_sobre", {31'h0, sobrescrita}, 32'h1);
        release_btn(12);
        press_capture("sim_c", 4'h7, 2'b10, 1'b0);
        chk("sim_c_sobre", {31'h0, sobrescrita}, 32'h0);
        release_btn(12);
        chk("sim_c_keep", {31'h0, dadoPronto}, 32'h1);

        // Reset mid-filter with data pending; held button recaptured
        entradaDeDados = 4'h6;
        botaoIN        = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("mrst_pronto", {31'h0, dadoPronto},    32'h0);
        chk("mrst_dado",   {28'h0, dadoCapturado}, 32'h0);
        chk("mrst_ext",    dadoEstendido,          32'h0);
        chk("mrst_sobre",  {31'h0, sobrescrita},   32'h0);
        press_capture("mrst_recap", 4'h6, 2'b00, 1'b1);
        chk("mrst_sobre2", {31'h0, sobrescrita}, 32'h0);
        tick(20);
        chk("mrst_once", {28'h0, dadoCapturado}, 32'h6);

        chk("sb_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/entrada_captura.md
ENTRADA_CAPTURA -- requirements
Module: entrada_captura

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, default 50000, number of consecutive stable synchronized cycles needed to accept a button edge; legal range 2..2^20.
REQ-002 SHALL have parameter: PRESS_LEVEL, default 1'b0, raw botaoIN level meaning "pressed" (board keys are active-low).
REQ-003 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: botaoIN  input  1  raw asynchronous push-button.
REQ-006 SHALL have port: entradaDeDados  input  4  raw asynchronous switch value.
REQ-007 SHALL have port: entradaSaidaControl  input  2  processor I/O control; 2'b10 = input read (consume).
REQ-008 SHALL have port: dadoCapturado  output  4  latched switch value.
REQ-009 SHALL have port: dadoEstendido  output  32  {28'b0, dadoCapturado}, feeds the I/O unit read path.
REQ-010 SHALL have port: dadoPronto  output  1  a captured value is waiting to be consumed.
REQ-011 SHALL have port: sobrescrita  output  1  sticky overrun flag.
REQ-012 SHALL have port: paraProcessador  output  1  stall request while an input read waits for data.

Function
REQ-013 SHALL pass botaoIN and each entradaDeDados bit through two-flop synchronizers (botaoS, chavesS); no other logic reads the raw inputs.
REQ-014 SHALL implement FSM states OCIOSO, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA.
REQ-015 OCIOSO: botaoS == PRESS_LEVEL -> FILTRA_PRESS, contador <= 0; else stay.
REQ-016 FILTRA_PRESS: botaoS not pressed -> OCIOSO, contador <= 0 (glitch rejected, no capture); pressed and contador == DEBOUNCE_CYCLES-1 -> PRESSIONADO plus capture; else contador++.
REQ-017 PRESSIONADO: botaoS released -> FILTRA_SOLTA, contador <= 0; else stay (holding button never recaptures).
REQ-018 FILTRA_SOLTA: botaoS pressed -> PRESSIONADO, contador <= 0; released and contador == DEBOUNCE_CYCLES-1 -> OCIOSO; else contador++.
REQ-019 contador SHALL be $clog2(DEBOUNCE_CYCLES) bits wide minimum and never wrap.
REQ-020 Capture: on the FILTRA_PRESS->PRESSIONADO edge, dadoCapturado <= chavesS and dadoPronto <= 1.
REQ-021 Latency: with stable inputs, dadoPronto SHALL rise on rising edge DEBOUNCE_CYCLES+3 counted from the first edge sampling botaoIN pressed (edge 1).
REQ-022 Consume: on an edge with entradaSaidaControl == 2'b10 and dadoPronto == 1, dadoPronto <= 0 and sobrescrita <= 0; dadoCapturado holds its value.
REQ-023 Capture and consume on the same edge: capture wins; dadoPronto stays 1, dadoCapturado takes new value, sobrescrita <= 0.
REQ-024 Capture while dadoPronto == 1 without consume: dadoCapturado overwritten, sobrescrita <= 1 until next consume or reset.
REQ-025 paraProcessador SHALL be combinational: (entradaSaidaControl == 2'b10) && !dadoPronto.
REQ-026 dadoEstendido SHALL be combinational from dadoCapturado, upper 28 bits always 0.
REQ-027 entradaSaidaControl values 2'b00, 2'b01, 2'b11 SHALL have no effect on any state.

Reset
REQ-028 reset == 0 at a rising edge SHALL force: state OCIOSO, contador 0, both synchronizer stages of botaoS to the released level (~PRESS_LEVEL), chavesS 0, dadoCapturado 4'h0, dadoPronto 0, sobrescrita 0.
REQ-029 Reset asserted mid-filter or with dadoPronto == 1 SHALL discard the pending press/data; a button still held after reset release SHALL be captured once after full debounce.

Verification (DEBOUNCE_CYCLES = 4, PRESS_LEVEL = 0)
REQ-030 Clean press: switches 4'hA, botaoIN 0 held from edge 1 -> dadoPronto 1 at edge 7, dadoCapturado 4'hA, dadoEstendido 32'h0000000A, sobrescrita 0.
REQ-031 Glitch: botaoIN 0 for 3 cycles then 1 -> dadoPronto stays 0, FSM back in OCIOSO; button held 60 cycles -> exactly one capture.
REQ-032 Stall/consume: entradaSaidaControl 2'b10 with dadoPronto 0 -> paraProcessador 1; after capture of 4'h5, paraProcessador 0 and one edge later dadoPronto 0, dadoCapturado still 4'h5.
REQ-033 Overrun: capture 4'h3, release >= 4 cycles, capture 4'hC without consume -> dadoCapturado 4'hC, sobrescrita 1; consume -> sobrescrita 0, dadoPronto 0.
REQ-034 Simultaneous: consume on the capture edge of 4'h7 -> dadoPronto stays 1, dadoCapturado 4'h7, sobrescrita 0.
REQ-035 Reset mid-operation: reset low 1 edge while in FILTRA_PRESS with dadoPronto 1 -> all outputs 0 next cycle; held button recaptured at edge 7 after reset release.
